// File: rtl/eco32f_defs.sv
// Shared definitions for the eco32f Wishbone arbiter: grant encodings,
// Wishbone cycle-type constants and the packed master request bundle.
package eco32f_defs;

    typedef enum logic [1:0] {
        GNT_NONE = 2'd0,
        GNT_I    = 2'd1,
        GNT_D    = 2'd2
    } gnt_e;

    localparam logic [2:0] CTI_CLASSIC = 3'b000;
    localparam logic [2:0] CTI_INC     = 3'b010;
    localparam logic [2:0] CTI_EOB     = 3'b111;
    localparam logic [1:0] BTE_WRAP8   = 2'b10;

    localparam int TMO_W = 10;

    typedef struct packed {
        logic [31:0] adr;
        logic [31:0] dat;
        logic [3:0]  sel;
        logic        we;
        logic [2:0]  cti;
        logic [1:0]  bte;
        logic        stb;
        logic        cyc;
    } wb_req_t;

    localparam wb_req_t WB_REQ_IDLE = '{
        adr: 32'h0000_0000,
        dat: 32'h0000_0000,
        sel: 4'h0,
        we:  1'b0,
        cti: 3'b000,
        bte: 2'b00,
        stb: 1'b0,
        cyc: 1'b0
    };

    function automatic logic wb_resp_any(input logic ack, input logic err, input logic rty);
        return ack | err | rty;
    endfunction

endpackage

// File: rtl/eco32f_wb_timeout.sv
// Bus wait counter: counts owner stall cycles and raises a single-cycle
// expire pulse when TIMEOUT cycles have elapsed (TIMEOUT = 0 disables it).
module eco32f_wb_timeout
    import eco32f_defs::*;
#(
    parameter int TIMEOUT = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic expire
);

    localparam bit TO_ON = (TIMEOUT > 0);
    localparam logic [TMO_W-1:0] LAST_CNT = TO_ON ? TMO_W'(TIMEOUT - 1) : {TMO_W{1'b0}};

    logic [TMO_W-1:0] cnt_r;
    logic             hit_s;

    // Expiry is combinational so the err reaches the owner in the limit cycle itself.
    always_comb begin
        hit_s = 1'b0;
        if (TO_ON && en && !clr) begin
            hit_s = (cnt_r == LAST_CNT);
        end else begin
            hit_s = 1'b0;
        end
    end

    assign expire = hit_s;

    // Stall counter; restarts after an expiry so the pulse cannot repeat.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_r <= {TMO_W{1'b0}};
        end else if (clr || hit_s) begin
            cnt_r <= {TMO_W{1'b0}};
        end else if (en) begin
            cnt_r <= cnt_r + TMO_W'(1);
        end else begin
            cnt_r <= cnt_r;
        end
    end

endmodule

// File: rtl/eco32f_wb_arbiter.sv
// Two-master (fetch I / load-store D) Wishbone B3 bus arbiter with cycle-long
// grant hold and hung-slave timeout. ECO32F_WB_ARB_RR_EN selects round-robin ties.
module eco32f_wb_arbiter
    import eco32f_defs::*;
#(
    parameter int TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst,

    input  logic [31:0] iwbm_adr_i,
    input  logic [31:0] iwbm_dat_i,
    input  logic [3:0]  iwbm_sel_i,
    input  logic        iwbm_we_i,
    input  logic [2:0]  iwbm_cti_i,
    input  logic [1:0]  iwbm_bte_i,
    input  logic        iwbm_stb_i,
    input  logic        iwbm_cyc_i,
    output logic        iwbm_ack_o,
    output logic        iwbm_err_o,
    output logic        iwbm_rty_o,
    output logic [31:0] iwbm_dat_o,

    input  logic [31:0] dwbm_adr_i,
    input  logic [31:0] dwbm_dat_i,
    input  logic [3:0]  dwbm_sel_i,
    input  logic        dwbm_we_i,
    input  logic [2:0]  dwbm_cti_i,
    input  logic [1:0]  dwbm_bte_i,
    input  logic        dwbm_stb_i,
    input  logic        dwbm_cyc_i,
    output logic        dwbm_ack_o,
    output logic        dwbm_err_o,
    output logic        dwbm_rty_o,
    output logic [31:0] dwbm_dat_o,

    output logic [31:0] wbm_adr_o,
    output logic [31:0] wbm_dat_o,
    output logic [3:0]  wbm_sel_o,
    output logic        wbm_we_o,
    output logic [2:0]  wbm_cti_o,
    output logic [1:0]  wbm_bte_o,
    output logic        wbm_stb_o,
    output logic        wbm_cyc_o,
    input  logic        wbm_ack_i,
    input  logic        wbm_err_i,
    input  logic        wbm_rty_i,
    input  logic [31:0] wbm_dat_i
);

    wb_req_t i_req_s;
    wb_req_t d_req_s;
    wb_req_t own_req_s;
    gnt_e    gnt_r;
    gnt_e    gnt_nxt_s;
    gnt_e    tie_win_s;
    logic    arb_s;
    logic    resp_s;
    logic    to_en_s;
    logic    to_clr_s;
    logic    expire_s;
    logic    timed_out_r;
    logic    kill_s;
    logic    i_own_s;
    logic    d_own_s;

    assign i_req_s = '{adr: iwbm_adr_i, dat: iwbm_dat_i, sel: iwbm_sel_i, we: iwbm_we_i,
                       cti: iwbm_cti_i, bte: iwbm_bte_i, stb: iwbm_stb_i, cyc: iwbm_cyc_i};
    assign d_req_s = '{adr: dwbm_adr_i, dat: dwbm_dat_i, sel: dwbm_sel_i, we: dwbm_we_i,
                       cti: dwbm_cti_i, bte: dwbm_bte_i, stb: dwbm_stb_i, cyc: dwbm_cyc_i};

    // Owner request mux; nothing is driven onto the bus without a grant.
    always_comb begin
        own_req_s = WB_REQ_IDLE;
        case (gnt_r)
            GNT_I:   own_req_s = i_req_s;
            GNT_D:   own_req_s = d_req_s;
            default: own_req_s = WB_REQ_IDLE;
        endcase
    end

    // The grant is only reconsidered while the owner has its cycle line low.
    assign arb_s = (gnt_r == GNT_NONE) || !own_req_s.cyc;

`ifdef ECO32F_WB_ARB_RR_EN
    gnt_e last_r;

    // Most recent grant; the other master takes the next simultaneous request.
    always_ff @(posedge clk) begin
        if (rst) begin
            last_r <= GNT_I;
        end else if (arb_s && (gnt_nxt_s != GNT_NONE)) begin
            last_r <= gnt_nxt_s;
        end else begin
            last_r <= last_r;
        end
    end

    assign tie_win_s = (last_r == GNT_I) ? GNT_D : GNT_I;
`else
    assign tie_win_s = GNT_D;
`endif

    // Next-grant selection.
    always_comb begin
        gnt_nxt_s = gnt_r;
        if (rst) begin
            gnt_nxt_s = GNT_NONE;
        end else if (arb_s) begin
            if (i_req_s.cyc && d_req_s.cyc) begin
                gnt_nxt_s = tie_win_s;
            end else if (d_req_s.cyc) begin
                gnt_nxt_s = GNT_D;
            end else if (i_req_s.cyc) begin
                gnt_nxt_s = GNT_I;
            end else begin
                gnt_nxt_s = GNT_NONE;
            end
        end else begin
            gnt_nxt_s = gnt_r;
        end
    end

    // Grant state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            gnt_r <= GNT_NONE;
        end else begin
            gnt_r <= gnt_nxt_s;
        end
    end

    assign resp_s   = wb_resp_any(wbm_ack_i, wbm_err_i, wbm_rty_i);
    assign to_en_s  = own_req_s.stb && !resp_s && !timed_out_r;
    assign to_clr_s = !own_req_s.stb || resp_s || (gnt_nxt_s != gnt_r);

    eco32f_wb_timeout #(
        .TIMEOUT (TIMEOUT)
    ) u_timeout (
        .clk    (clk),
        .rst    (rst),
        .clr    (to_clr_s),
        .en     (to_en_s),
        .expire (expire_s)
    );

    // After an expiry the slave is cut off until the owner abandons the cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            timed_out_r <= 1'b0;
        end else if (expire_s) begin
            timed_out_r <= 1'b1;
        end else if (!own_req_s.cyc) begin
            timed_out_r <= 1'b0;
        end else begin
            timed_out_r <= timed_out_r;
        end
    end

    assign kill_s = expire_s || timed_out_r;

    assign wbm_adr_o = own_req_s.adr;
    assign wbm_dat_o = own_req_s.dat;
    assign wbm_sel_o = own_req_s.sel;
    assign wbm_we_o  = own_req_s.we;
    assign wbm_cti_o = own_req_s.cti;
    assign wbm_bte_o = own_req_s.bte;
    assign wbm_stb_o = own_req_s.stb && !kill_s;
    assign wbm_cyc_o = own_req_s.cyc && !kill_s;

    assign i_own_s = (gnt_r == GNT_I);
    assign d_own_s = (gnt_r == GNT_D);

    assign iwbm_ack_o = i_own_s && wbm_ack_i;
    assign iwbm_err_o = i_own_s && (wbm_err_i || expire_s);
    assign iwbm_rty_o = i_own_s && wbm_rty_i;
    assign dwbm_ack_o = d_own_s && wbm_ack_i;
    assign dwbm_err_o = d_own_s && (wbm_err_i || expire_s);
    assign dwbm_rty_o = d_own_s && wbm_rty_i;

    assign iwbm_dat_o = wbm_dat_i;
    assign dwbm_dat_o = wbm_dat_i;

endmodule
